y86_prog_loader: RTL and testbench

- Feeds the SEQ Y86-64 core from the outside, where the bench only observes it.
- Accepts a byte-serial program image over a valid/ready stream, with a 2-byte length header followed by payload.
- Writes the payload into instruction memory from address 0, then releases the core from reset.
- Watches the core's 2-bit Status until it leaves AOK, then reports final status and executed cycle count; a watchdog bounds runaway programs.

---
 rtl/y86_prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_y86_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_prog_loader.sv
// Loads a length-prefixed byte-serial program image into instruction memory,
// releases the Y86-64 core from reset, then records its final status and cycle count.
module y86_prog_loader #(
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_rst_n,
    input  logic [1:0]        cpu_status,
    output logic              done,
    output logic [1:0]        final_status,
    output logic              timeout,
    output logic              err_overflow,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [16:0]      CAPACITY = 17'd1 << ADDR_W;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [15:0]         rem_q, rem_d;
    logic                in_ready_q, in_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [7:0]          imem_wdata_q, imem_wdata_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                done_q, done_d;
    logic [1:0]          final_status_q, final_status_d;
    logic                timeout_q, timeout_d;
    logic                err_overflow_q, err_overflow_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;

    // Valid/ready: a byte moves on a rising edge where in_valid and in_ready are both 1.
    logic                xfer;
    logic [15:0]         len_full;
    logic [CNT_W-1:0]    cnt_inc;

    assign xfer     = in_valid & in_ready_q;
    assign len_full = {in_data, len_lo_q};
    assign cnt_inc  = cycle_count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_HDR0;
            len_lo_q       <= '0;
            ptr_q          <= '0;
            rem_q          <= '0;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_rst_n_q    <= 1'b0;
            done_q         <= 1'b0;
            final_status_q <= 2'b00;
            timeout_q      <= 1'b0;
            err_overflow_q <= 1'b0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            ptr_q          <= ptr_d;
            rem_q          <= rem_d;
            in_ready_q     <= in_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            done_q         <= done_d;
            final_status_q <= final_status_d;
            timeout_q      <= timeout_d;
            err_overflow_q <= err_overflow_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        len_lo_d       = len_lo_q;
        ptr_d          = ptr_q;
        rem_d          = rem_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        done_d         = done_q;
        final_status_d = final_status_q;
        timeout_d      = timeout_q;
        err_overflow_d = err_overflow_q;
        cycle_count_d  = cycle_count_q;

        case (state_q)
            S_HDR0: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        state_d = S_START;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        err_overflow_d = 1'b1;
                        done_d         = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        ptr_d   = '0;
                        rem_d   = len_full;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q;
                    imem_wdata_d = in_data;
                    ptr_d        = ptr_q + ADDR_W'(1);
                    rem_d        = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_START;
                end
            end
            S_START: begin
                // The last imem write lands during this cycle; release follows it.
                cycle_count_d = '0;
                cpu_rst_n_d   = 1'b1;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (cpu_status != 2'b00) begin
                    final_status_d = cpu_status;
                    done_d         = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    cycle_count_d = cnt_inc;
                    if (cnt_inc == MAX_CNT) begin
                        timeout_d      = 1'b1;
                        done_d         = 1'b1;
                        final_status_d = 2'b00;
                        state_d        = S_DONE;
                    end
                end
            end
            S_DONE: begin
            end
            default: state_d = S_HDR0;
        endcase
    end

    assign in_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD);

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign done         = done_q;
    assign final_status = final_status_q;
    assign timeout      = timeout_q;
    assign err_overflow = err_overflow_q;
    assign cycle_count  = cycle_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_y86_prog_loader.sv
// Bench for y86_prog_loader: drives program images, models the core's status,
// and checks imem writes, release timing and the final run report.
module tb_y86_prog_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;
    localparam int MAXC   = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              cpu_rst_n;
    logic [1:0]        cpu_status = 2'b00;
    logic              done;
    logic [1:0]        final_status;
    logic              timeout;
    logic              err_overflow;
    logic [CNT_W-1:0]  cycle_count;
    logic [2:0]        dbg_state;

    y86_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .cpu_status(cpu_status),
        .done(done), .final_status(final_status), .timeout(timeout),
        .err_overflow(err_overflow), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Expected imem writes in order: {addr, data}.
    logic [ADDR_W+7:0] exp_q[$];
    logic [7:0]        img_q[$];

    // Core model: AOK for n_aok released cycles, then end_st.
    int         n_aok  = 0;
    logic [1:0] end_st = 2'b01;
    int         core_k = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!cpu_rst_n) begin
            core_k     = 0;
            cpu_status = 2'b00;
        end else begin
            cpu_status = (core_k >= n_aok) ? end_st : 2'b00;
            core_k++;
        end
    end

    // Compare process: every imem write must follow a payload transfer and match the image.
    int   idx = 0, hdr_len = 0, neg_cnt = 0;
    int   first_we_cyc = -1, last_we_cyc = -1, rise_cyc = -1;
    logic [7:0] hdr_lo = 8'h00;
    logic prev_pay = 1'b0;
    logic cur;
    logic [ADDR_W+7:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            idx = 0; hdr_len = 0; prev_pay = 1'b0;
            first_we_cyc = -1; last_we_cyc = -1; rise_cyc = -1;
        end else begin
            neg_cnt++;
            chk("imem_we_timing", 64'(imem_we), 64'(prev_pay));
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("imem_unexpected_write", 64'(imem_we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("imem_addr", 64'(imem_addr), 64'(e[ADDR_W+7:8]));
                    chk("imem_wdata", 64'(imem_wdata), 64'(e[7:0]));
                end
                if (first_we_cyc < 0) first_we_cyc = neg_cnt;
                last_we_cyc = neg_cnt;
            end
            if (cpu_rst_n) begin
                if (rise_cyc < 0) begin
                    rise_cyc = neg_cnt;
                    chk("release_with_writes_pending", 64'(exp_q.size()), 64'd0);
                end
            end
            cur      = in_valid && in_ready;
            prev_pay = cur && (idx >= 2) && (idx < 2 + hdr_len);
            if (cur) begin
                if (idx == 0) hdr_lo = in_data;
                else if (idx == 1) hdr_len = int'({in_data, hdr_lo});
                idx++;
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_final_status", 64'(final_status), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_err_overflow", 64'(err_overflow), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..2 idle cycles.
    task automatic load_image(input int gap_mode, input int nbytes);
        int len;
        len = int'({img_q[1], img_q[0]});
        if (len <= (1 << ADDR_W))
            for (int i = 0; i < len; i++)
                exp_q.push_back({ADDR_W'(i), img_q[2+i]});
        for (int i = 0; i < nbytes; i++) begin
            send_byte(img_q[i]);
            if (gap_mode == 1) @(posedge clk);
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gap_mode != 0) #1;
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("wait_done", 64'(done), 64'd1);
    endtask

    task automatic check_run(input logic [1:0] st, input int cnt, input logic to, input int len);
        chk("done", 64'(done), 64'd1);
        chk("final_status", 64'(final_status), 64'(st));
        chk("cycle_count", 64'(cycle_count), 64'(cnt));
        chk("timeout", 64'(timeout), 64'(to));
        chk("err_overflow", 64'(err_overflow), 64'd0);
        chk("done_in_ready", 64'(in_ready), 64'd0);
        chk("cpu_rst_n_after_run", 64'(cpu_rst_n), 64'd1);
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
        if (len > 0) chk("release_delay", 64'(rise_cyc - last_we_cyc), 64'd1);
        repeat (3) @(negedge clk);
        chk("sticky_count", 64'(cycle_count), 64'(cnt));
        chk("sticky_done", 64'(done), 64'd1);
    endtask

    // Run-length rule: watchdog fires at MAXC AOK cycles unless the core stops first.
    task automatic run_and_check(input int gap_mode);
        int len;
        len = int'({img_q[1], img_q[0]});
        load_image(gap_mode, img_q.size());
        wait_done();
        if (n_aok >= MAXC) check_run(2'b00, MAXC, 1'b1, len);
        else check_run(end_st, n_aok, 1'b0, len);
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: 5-byte image, HLT after 3 AOK cycles, back-to-back.
        img_q = '{8'h05, 8'h00, 8'h30, 8'hF0, 8'h0A, 8'h00, 8'h00};
        n_aok = 3; end_st = 2'b01;
        load_image(0, 7);
        wait_done();
        check_run(2'b01, 3, 1'b0, 5);
        chk("b2b_write_span", 64'(last_we_cyc - first_we_cyc), 64'd4);

        // Same image with in_valid toggling.
        do_reset();
        n_aok = 3; end_st = 2'b01;
        run_and_check(1);

        // Empty program, INS on first RUN edge.
        do_reset();
        img_q = '{8'h00, 8'h00};
        n_aok = 0; end_st = 2'b11;
        load_image(0, 2);
        wait_done();
        check_run(2'b11, 0, 1'b0, 0);
        chk("empty_no_writes", 64'(first_we_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Overflow header: len 1025.
        do_reset();
        img_q = '{8'h01, 8'h04};
        load_image(0, 2);
        wait_done();
        repeat (5) @(negedge clk);
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_done", 64'(done), 64'd1);
        chk("ovf_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("ovf_in_ready", 64'(in_ready), 64'd0);
        chk("ovf_timeout", 64'(timeout), 64'd0);

        // Watchdog.
        do_reset();
        img_q = '{8'h02, 8'h00, 8'h10, 8'h00};
        n_aok = 1000; end_st = 2'b01;
        load_image(0, 4);
        wait_done();
        check_run(2'b00, 20, 1'b1, 2);

        // Reset mid-load after 2 of 5 payload bytes, then a full reload.
        do_reset();
        img_q = '{8'h05, 8'h00, 8'h30, 8'hF0, 8'h0A, 8'h00, 8'h00};
        load_image(0, 4);
        @(negedge clk);
        do_reset();
        n_aok = 3; end_st = 2'b01;
        run_and_check(0);

        // Exactly full capacity: addresses 0..1023, no overwrite.
        do_reset();
        img_q = '{8'h00, 8'h04};
        for (int i = 0; i < 1024; i++) img_q.push_back(8'($urandom_range(0, 255)));
        n_aok = 5; end_st = 2'b10;
        run_and_check(0);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            int len;
            do_reset();
            len = $urandom_range(1, 48);
            img_q = '{8'(len), 8'h00};
            for (int i = 0; i < len; i++) img_q.push_back(8'($urandom_range(0, 255)));
            n_aok  = $urandom_range(0, 25);
            end_st = 2'($urandom_range(1, 3));
            run_and_check(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
